arb_mux_n: RTL and testbench
============================

ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter DataPathSize, default 8, width of each data channel.
REQ-002 SHALL have parameter NumChannels, default 8, input channel count, 2..16.
REQ-003 SHALL have parameter SelWidth, default 3, SEL/OUT_CH width, equal to ceil(log2(NumChannels)).
REQ-004 SHALL have ports: CLK in 1, rising-edge clock; RST in 1, asynchronous active-high reset.
REQ-005 SHALL have ports: IN_DATA in NumChannels*DataPathSize, channel k at bits [k*DataPathSize +: DataPathSize]; IN_VALID in NumChannels; IN_LAST in NumChannels, last beat of a packet; IN_READY out NumChannels.
REQ-006 SHALL have ports: MODE in 1, 0=direct select, 1=round-robin; SEL in SelWidth, channel used when MODE=0.
REQ-007 SHALL have ports: OUT_DATA out DataPathSize; OUT_CH out SelWidth, source channel of OUT_DATA; OUT_LAST out 1; OUT_VALID out 1; OUT_READY in 1.

Function
REQ-008 SHALL hold one registered output beat: OUT_DATA, OUT_CH, OUT_LAST and OUT_VALID driven only from flops.
REQ-009 SHALL define load = !OUT_VALID || OUT_READY; a beat is accepted from channel g when load && IN_VALID[g] && grant==g.
REQ-010 SHALL assert IN_READY[k] combinationally only for k==grant and only while load=1; all other bits 0.
REQ-011 SHALL give a latency of one cycle: a beat accepted at edge n appears on OUT_* after edge n, with OUT_VALID=1.
REQ-012 SHALL clear OUT_VALID when OUT_READY=1 and no beat is accepted in the same cycle; OUT_* hold value while OUT_VALID=1 and OUT_READY=0.
REQ-013 SHALL sustain one beat per cycle when OUT_READY stays 1 and the granted channel stays valid.
REQ-014 In MODE=0, SHALL set grant=SEL; SEL >= NumChannels SHALL grant nothing (IN_READY all 0).
REQ-015 In MODE=1, SHALL grant the first valid channel scanning upward from PTR+1 mod NumChannels, wrapping to PTR itself last; no valid channel means no grant.
REQ-016 SHALL update PTR to the granted channel on every accepted beat in MODE=1; PTR SHALL not change in MODE=0 or when no beat is accepted.
REQ-017 SHALL give simultaneous requests exactly one grant per cycle; a continuously valid channel SHALL be granted within NumChannels accepted beats.
REQ-018 SHALL apply a MODE or SEL change at the next accepted beat; a beat already in the output register SHALL be unaffected.
REQ-019 SHALL copy IN_LAST[g] into OUT_LAST with the accepted beat.

Reset
REQ-020 SHALL, while RST=1, asynchronously force OUT_VALID=0, OUT_DATA=0, OUT_CH=0, OUT_LAST=0, PTR=NumChannels-1, and LOCK=0 when present.
REQ-021 SHALL drive IN_READY all 0 while RST=1; an in-flight output beat SHALL be discarded without a transfer.
REQ-022 SHALL accept the first beat at the first rising edge after RST deasserts, with channel 0 first in round-robin priority.

Configuration
REQ-023 SHALL provide macro ARB_MUX_PKT_LOCK_EN to enable packet lock in MODE=1.
REQ-024 With ARB_MUX_PKT_LOCK_EN defined: an accepted beat with IN_LAST=0 SHALL set LOCK, and grant SHALL stay on that channel, ignoring other requests, until a beat with IN_LAST=1 from it is accepted, which clears LOCK.
REQ-025 With ARB_MUX_PKT_LOCK_EN defined: MODE=0 SHALL clear LOCK, and a locked channel dropping IN_VALID SHALL stall the output rather than switch channel.
REQ-026 Without ARB_MUX_PKT_LOCK_EN: no LOCK flop; arbitration SHALL be per beat, with IN_LAST only passed through to OUT_LAST.

Verification
REQ-027 DataPathSize=8, NumChannels=8; MODE=0, SEL=5, IN_VALID=8'hFF, channel 5 data 8'hA5, OUT_READY=1 -> IN_READY=8'h20; next cycle OUT_DATA=8'hA5, OUT_CH=5, OUT_VALID=1.
REQ-028 MODE=1, IN_VALID=8'h91 (channels 0, 4, 7) held, OUT_READY=1 from reset -> OUT_CH sequence 0,4,7,0,4, one beat per cycle.
REQ-029 Output holding a beat with OUT_READY=0 for 3 cycles -> OUT_* stable, IN_READY=0; OUT_READY=1 -> next beat loaded in the same cycle with no bubble.
REQ-030 RST pulsed mid-stream while OUT_VALID=1 -> OUT_VALID=0 immediately (asynchronous); after release, round-robin restarts at channel 0.
REQ-031 With lock enabled: channel 2 sends 3 beats, IN_LAST only on beat 3, channel 6 valid throughout -> OUT_CH=2,2,2 then 6.
REQ-032 MODE=0, SEL=3'd6 with NumChannels=6 -> IN_READY all 0, OUT_VALID stays 0.

Source files
------------

// File: rtl/arb_mux_n_if.sv
// Bus bundle for arb_mux_n: N-channel input streams plus one registered output stream.
// The slave modport is the mux's view; master is the driver/sink side.
interface arb_mux_n_if #(
  parameter int unsigned DataPathSize = 8,
  parameter int unsigned NumChannels  = 8,
  parameter int unsigned SelWidth     = 3
) ();
  logic [NumChannels*DataPathSize-1:0] IN_DATA;
  logic [NumChannels-1:0]              IN_VALID;
  logic [NumChannels-1:0]              IN_LAST;
  logic [NumChannels-1:0]              IN_READY;
  logic                                MODE;
  logic [SelWidth-1:0]                 SEL;
  logic [DataPathSize-1:0]             OUT_DATA;
  logic [SelWidth-1:0]                 OUT_CH;
  logic                                OUT_LAST;
  logic                                OUT_VALID;
  logic                                OUT_READY;

  modport slave (
    input  IN_DATA, IN_VALID, IN_LAST, MODE, SEL, OUT_READY,
    output IN_READY, OUT_DATA, OUT_CH, OUT_LAST, OUT_VALID
  );

  modport master (
    output IN_DATA, IN_VALID, IN_LAST, MODE, SEL, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_CH, OUT_LAST, OUT_VALID
  );
endinterface

// File: rtl/arb_mux_n.sv
// N-to-1 stream mux with direct-select or round-robin arbitration and a one-beat output register.
// Define ARB_MUX_PKT_LOCK_EN to hold round-robin grant on a channel until its IN_LAST beat.
module arb_mux_n #(
  parameter int unsigned DataPathSize = 8,
  parameter int unsigned NumChannels  = 8,
  parameter int unsigned SelWidth     = 3
) (
  input logic        CLK,
  input logic        RST,
  arb_mux_n_if.slave bus
);

  logic                    out_valid_q, out_valid_d;
  logic [DataPathSize-1:0] out_data_q, out_data_d;
  logic [SelWidth-1:0]     out_ch_q, out_ch_d;
  logic                    out_last_q, out_last_d;
  logic [SelWidth-1:0]     ptr_q, ptr_d;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic                    lock_q, lock_d;
`endif

  logic                    load;
  logic                    accept;
  logic                    grant_vld;
  logic [SelWidth-1:0]     grant;
  logic [SelWidth-1:0]     cand;
  int unsigned             scan_idx;
  logic [NumChannels-1:0]  in_ready;
  logic [DataPathSize-1:0] in_data_arr [NumChannels];

  for (genvar k = 0; k < NumChannels; k++) begin : g_unpack
    assign in_data_arr[k] = bus.IN_DATA[k*DataPathSize +: DataPathSize];
  end

  assign load = !out_valid_q || bus.OUT_READY;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    cand      = '0;
    if (!bus.MODE) begin
      grant     = bus.SEL;
      grant_vld = (32'(bus.SEL) < NumChannels);
`ifdef ARB_MUX_PKT_LOCK_EN
    end else if (lock_q) begin
      // Locked channel is always the last granted one, which ptr_q tracks.
      grant     = ptr_q;
      grant_vld = 1'b1;
`endif
    end else begin
      // Walk offsets high to low so the nearest valid channel after ptr_q wins.
      for (int unsigned i = NumChannels; i >= 1; i--) begin
        scan_idx = 32'(ptr_q) + i;
        if (scan_idx >= NumChannels) begin
          scan_idx = scan_idx - NumChannels;
        end
        cand = SelWidth'(scan_idx);
        if (bus.IN_VALID[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign accept = load && grant_vld && bus.IN_VALID[grant];

  always_comb begin
    in_ready = '0;
    if (load && grant_vld && !RST) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign bus.IN_READY = in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data_arr[grant];
      out_ch_d    = grant;
      out_last_d  = bus.IN_LAST[grant];
      if (bus.MODE) begin
        ptr_d = grant;
      end
    end else if (bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef ARB_MUX_PKT_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    if (!bus.MODE) begin
      lock_d = 1'b0;
    end else if (accept) begin
      lock_d = !bus.IN_LAST[grant];
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= SelWidth'(NumChannels - 1);
`ifdef ARB_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
`ifdef ARB_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_CH    = out_ch_q;
  assign bus.OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: per-cycle comparison against a behavioural model,
// directed literal scenarios, then randomized traffic.
module tb_arb_mux_n;
  localparam int unsigned DW = 8;
  localparam int unsigned NC = 8;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_mux_n_if #(.DataPathSize(DW), .NumChannels(NC), .SelWidth(SW)) bus ();
  arb_mux_n_if #(.DataPathSize(DW), .NumChannels(6), .SelWidth(3)) bus6 ();

  arb_mux_n #(.DataPathSize(DW), .NumChannels(NC), .SelWidth(SW)) u_dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  arb_mux_n #(.DataPathSize(DW), .NumChannels(6), .SelWidth(3)) u_dut6 (
    .CLK(clk),
    .RST(rst),
    .bus(bus6)
  );

  int checks = 0;
  int errors = 0;

  // Model state: the beat held at the output plus arbitration pointer and lock.
  bit       m_valid = 1'b0;
  bit [7:0] m_data  = 8'h00;
  int       m_ch    = 0;
  bit       m_last  = 1'b0;
  int       m_ptr   = NC - 1;
  bit       m_lock  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model at the negedge, advance the model, return at posedge+1.
  task automatic cycle();
    bit       gv, ld, acc;
    int       g, c;
    bit [7:0] exp_rdy;
    @(negedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_last = 1'b0; m_ptr = NC - 1; m_lock = 1'b0;
    end
    ld = !m_valid || bus.OUT_READY;
    gv = 1'b0;
    g  = 0;
    if (!bus.MODE) begin
      g  = int'(bus.SEL);
      gv = (g < int'(NC));
    end else if (m_lock) begin
      g  = m_ptr;
      gv = 1'b1;
    end else begin
      for (int off = 1; off <= int'(NC); off++) begin
        c = (m_ptr + off) % int'(NC);
        if (!gv && bus.IN_VALID[c[SW-1:0]]) begin
          g  = c;
          gv = 1'b1;
        end
      end
    end
    exp_rdy = 8'h00;
    exp_rdy[g[SW-1:0]] = gv && ld && !rst;
    chk("model_in_ready", 32'(bus.IN_READY), 32'(exp_rdy));
    chk("model_out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
    if (m_valid || rst) begin
      chk("model_out_data", 32'(bus.OUT_DATA), 32'(m_data));
      chk("model_out_ch", 32'(bus.OUT_CH), 32'(m_ch));
      chk("model_out_last", 32'(bus.OUT_LAST), 32'(m_last));
    end
    if (!rst) begin
      acc = ld && gv && bus.IN_VALID[g[SW-1:0]];
      if (acc) begin
        m_valid = 1'b1;
        m_data  = 8'(bus.IN_DATA >> (g * int'(DW)));
        m_ch    = g;
        m_last  = bus.IN_LAST[g[SW-1:0]];
      end else if (bus.OUT_READY) begin
        m_valid = 1'b0;
      end
      if (acc && bus.MODE) m_ptr = g;
`ifdef ARB_MUX_PKT_LOCK_EN
      if (!bus.MODE) m_lock = 1'b0;
      else if (acc) m_lock = !bus.IN_LAST[g[SW-1:0]];
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_seq[5];
    int pkt_seq[4];
    rr_seq = '{0, 4, 7, 0, 4};
`ifdef ARB_MUX_PKT_LOCK_EN
    pkt_seq = '{2, 2, 2, 6};
`else
    pkt_seq = '{2, 6, 2, 6};
`endif

    rst            = 1'b1;
    bus.MODE       = 1'b0;
    bus.SEL        = 3'd5;
    bus.IN_VALID   = 8'hFF;
    bus.IN_LAST    = 8'h00;
    for (int k = 0; k < int'(NC); k++) bus.IN_DATA[k*DW +: DW] = 8'hA0 + 8'(k);
    bus.OUT_READY  = 1'b1;
    bus6.MODE      = 1'b0;
    bus6.SEL       = 3'd6;
    bus6.IN_VALID  = 6'h3F;
    bus6.IN_LAST   = 6'h00;
    bus6.IN_DATA   = '1;
    bus6.OUT_READY = 1'b1;

    // Reset state, with requests pending.
    #2;
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_out_data", 32'(bus.OUT_DATA), 32'd0);
    chk("rst_out_ch", 32'(bus.OUT_CH), 32'd0);
    chk("rst_out_last", 32'(bus.OUT_LAST), 32'd0);
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    cycle();

    // Direct select of channel 5.
    rst = 1'b0;
    #1;
    chk("sel5_in_ready", 32'(bus.IN_READY), 32'h20);
    cycle();
    chk("sel5_out_data", 32'(bus.OUT_DATA), 32'hA5);
    chk("sel5_out_ch", 32'(bus.OUT_CH), 32'd5);
    chk("sel5_out_valid", 32'(bus.OUT_VALID), 32'd1);

    // Async reset drops a held beat; round-robin over channels 0, 4, 7.
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.OUT_VALID), 32'd0);
    bus.MODE     = 1'b1;
    bus.IN_VALID = 8'h91;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_out_ch", 32'(bus.OUT_CH), 32'(rr_seq[i]));
      chk("rr_out_valid", 32'(bus.OUT_VALID), 32'd1);
    end

    // Backpressure: hold channel 4 beat for 3 cycles, then resume without a bubble.
    bus.OUT_READY = 1'b0;
    #1;
    chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_out_ch", 32'(bus.OUT_CH), 32'd4);
      chk("stall_out_data", 32'(bus.OUT_DATA), 32'hA4);
      chk("stall_out_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    bus.OUT_READY = 1'b1;
    #1;
    chk("resume_in_ready", 32'(bus.IN_READY), 32'h80);
    cycle();
    chk("resume_out_ch", 32'(bus.OUT_CH), 32'd7);
    chk("resume_out_data", 32'(bus.OUT_DATA), 32'hA7);

    // Mid-stream reset pulse restarts round-robin at channel 0.
    rst = 1'b1;
    #1;
    chk("pulse_rst_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("pulse_rst_ready", 32'(bus.IN_READY), 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("restart_out_ch", 32'(bus.OUT_CH), 32'd0);
    chk("restart_out_valid", 32'(bus.OUT_VALID), 32'd1);

    // Six-channel instance with SEL beyond the channel count grants nothing.
    for (int i = 0; i < 3; i++) begin
      chk("n6_in_ready", 32'(bus6.IN_READY), 32'd0);
      chk("n6_out_valid", 32'(bus6.OUT_VALID), 32'd0);
      cycle();
    end

    // Three-beat packet on channel 2 competing with channel 6.
    rst = 1'b1;
    bus.IN_VALID = 8'h44;
    bus.IN_LAST  = 8'h40;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.IN_LAST = 8'h44;
      cycle();
      chk("pkt_out_ch", 32'(bus.OUT_CH), 32'(pkt_seq[i]));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bus.MODE      = ($urandom_range(0, 3) != 0);
      bus.SEL       = 3'($urandom_range(0, 7));
      bus.IN_VALID  = (i % 3 == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
      bus.IN_LAST   = 8'($urandom);
      bus.IN_DATA   = {$urandom, $urandom};
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
